// File: rtl/bcd_modulo_register_pkg.sv
// Shared clock-datapath constants and BCD helpers for the modulo counter.
// Range constants cover seconds/minutes, 24-hour and 12-hour hour registers.
package bcd_modulo_register_pkg;

  localparam int BCD_W      = 4;
  localparam int SEC_MIN_MAX = 59;
  localparam int HOUR24_MAX  = 23;
  localparam int HOUR12_MIN  = 1;
  localparam int HOUR12_MAX  = 12;

  // Decimal 0..99 to packed {tens, units} BCD.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = BCD_W'(v / 10);
    units = BCD_W'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_modulo_register_digit_step.sv
// One BCD digit plus or minus one with 9<->0 wrap; wrap_o flags carry or borrow.
// Non-BCD inputs are treated as wrapping so they never propagate.
module bcd_digit_step
  import bcd_modulo_register_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  input  logic             down_i,
  output logic [BCD_W-1:0] q_o,
  output logic             wrap_o
);

  always_comb begin
    q_o    = d_i;
    wrap_o = 1'b0;
    if (down_i) begin
      if (d_i == 4'd0 || d_i > 4'd9) begin
        q_o    = 4'd9;
        wrap_o = 1'b1;
      end else begin
        q_o = d_i - 4'd1;
      end
    end else begin
      if (d_i >= 4'd9) begin
        q_o    = 4'd0;
        wrap_o = 1'b1;
      end else begin
        q_o = d_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_modulo_register.sv
// Two-digit BCD up/down counter modulo [MIN_VALUE, MAX_VALUE] with validated load.
// One cycle from en/load to data; overflow/underflow are combinational for chaining.
module bcd_modulo_register
  import bcd_modulo_register_pkg::*;
#(
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = 59,
  parameter int RESET_VALUE = MIN_VALUE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [BCD_W-1:0] load_msd,
  input  logic [BCD_W-1:0] load_lsd,
  output logic [BCD_W-1:0] data_msd,
  output logic [BCD_W-1:0] data_lsd,
  output logic             overflow,
  output logic             underflow,
  output logic             load_err
);

  localparam logic [2*BCD_W-1:0] MIN_BCD   = to_bcd(MIN_VALUE);
  localparam logic [2*BCD_W-1:0] MAX_BCD   = to_bcd(MAX_VALUE);
  localparam logic [2*BCD_W-1:0] RESET_BCD = to_bcd(RESET_VALUE);
  localparam logic [8:0]         MIN_V9    = 9'(MIN_VALUE);
  localparam logic [8:0]         MAX_V9    = 9'(MAX_VALUE);

  logic [BCD_W-1:0] msd_q, msd_d;
  logic [BCD_W-1:0] lsd_q, lsd_d;
  logic             load_err_q, load_err_d;

  logic [BCD_W-1:0] msd_step, lsd_step;
  logic             msd_wrap, lsd_wrap;
  logic [8:0]       cur_val, load_val;
  logic             cur_ok, load_ok, at_min, at_max;

  bcd_digit_step u_lsd (
    .d_i    (lsd_q),
    .down_i (down),
    .q_o    (lsd_step),
    .wrap_o (lsd_wrap)
  );

  bcd_digit_step u_msd (
    .d_i    (msd_q),
    .down_i (down),
    .q_o    (msd_step),
    .wrap_o (msd_wrap)
  );

  // Range checks use value+1 > MIN so a zero minimum needs no special case.
  assign cur_val  = 9'(msd_q) * 9'd10 + 9'(lsd_q);
  assign load_val = 9'(load_msd) * 9'd10 + 9'(load_lsd);
  assign cur_ok   = (msd_q <= 4'd9) && (lsd_q <= 4'd9) &&
                    (cur_val + 9'd1 > MIN_V9) && (cur_val <= MAX_V9);
  assign load_ok  = (load_msd <= 4'd9) && (load_lsd <= 4'd9) &&
                    (load_val + 9'd1 > MIN_V9) && (load_val <= MAX_V9);
  assign at_min   = ({msd_q, lsd_q} == MIN_BCD);
  assign at_max   = ({msd_q, lsd_q} == MAX_BCD);

  assign overflow  = en & ~down & ~load & at_max;
  assign underflow = en &  down & ~load & at_min;

  always_comb begin
    msd_d      = msd_q;
    lsd_d      = lsd_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        msd_d = load_msd;
        lsd_d = load_lsd;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      // Wrap on the full two-digit value; a stray state recovers to the range end.
      if (!cur_ok || (lsd_wrap && msd_wrap)) begin
        {msd_d, lsd_d} = down ? MAX_BCD : MIN_BCD;
      end else if (down && at_min) begin
        {msd_d, lsd_d} = MAX_BCD;
      end else if (!down && at_max) begin
        {msd_d, lsd_d} = MIN_BCD;
      end else begin
        lsd_d = lsd_step;
        msd_d = lsd_wrap ? msd_step : msd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      msd_q      <= RESET_BCD[2*BCD_W-1:BCD_W];
      lsd_q      <= RESET_BCD[BCD_W-1:0];
      load_err_q <= 1'b0;
    end else begin
      msd_q      <= msd_d;
      lsd_q      <= lsd_d;
      load_err_q <= load_err_d;
    end
  end

  assign data_msd = msd_q;
  assign data_lsd = lsd_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_modulo_register.sv
// Scoreboard bench: 0-59, 1-12 and 0-23 counters share stimulus; a 0-59 minutes
// stage is chained from the seconds stage's overflow/underflow.
module tb_bcd_modulo_register;

  localparam int NI = 4;

  typedef struct packed {
    logic [3:0] msd;
    logic [3:0] lsd;
    logic       ov;
    logic       un;
    logic       err;
  } obs_t;

  typedef struct packed {
    obs_t [NI-1:0] inst;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n, en, down, load;
  logic [3:0] lm, ll;

  logic [3:0] msd_w [NI];
  logic [3:0] lsd_w [NI];
  logic       ov_w  [NI];
  logic       un_w  [NI];
  logic       err_w [NI];
  logic       chain_en;

  always #5 clk = ~clk;

  assign chain_en = ov_w[0] | un_w[0];

  bcd_modulo_register #(.MIN_VALUE(0), .MAX_VALUE(59), .RESET_VALUE(0)) u_sec (
    .clk(clk), .reset_n(rst_n), .en(en), .down(down), .load(load),
    .load_msd(lm), .load_lsd(ll), .data_msd(msd_w[0]), .data_lsd(lsd_w[0]),
    .overflow(ov_w[0]), .underflow(un_w[0]), .load_err(err_w[0]));

  bcd_modulo_register #(.MIN_VALUE(1), .MAX_VALUE(12), .RESET_VALUE(12)) u_h12 (
    .clk(clk), .reset_n(rst_n), .en(en), .down(down), .load(load),
    .load_msd(lm), .load_lsd(ll), .data_msd(msd_w[1]), .data_lsd(lsd_w[1]),
    .overflow(ov_w[1]), .underflow(un_w[1]), .load_err(err_w[1]));

  bcd_modulo_register #(.MIN_VALUE(0), .MAX_VALUE(23), .RESET_VALUE(0)) u_h24 (
    .clk(clk), .reset_n(rst_n), .en(en), .down(down), .load(load),
    .load_msd(lm), .load_lsd(ll), .data_msd(msd_w[2]), .data_lsd(lsd_w[2]),
    .overflow(ov_w[2]), .underflow(un_w[2]), .load_err(err_w[2]));

  bcd_modulo_register u_min (
    .clk(clk), .reset_n(rst_n), .en(chain_en), .down(down), .load(1'b0),
    .load_msd(4'd0), .load_lsd(4'd0), .data_msd(msd_w[3]), .data_lsd(lsd_w[3]),
    .overflow(ov_w[3]), .underflow(un_w[3]), .load_err(err_w[3]));

  // Reference model: plain decimal values per instance.
  int minv [NI] = '{0, 1, 0, 0};
  int maxv [NI] = '{59, 12, 23, 59};
  int rstv [NI] = '{0, 12, 0, 0};
  int mval [NI];
  bit merr [NI];

  frame_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;

  task automatic cycle(input bit r, input bit e, input bit d, input bit l,
                       input int tens, input int units);
    frame_t f;
    bit     ov_m [NI];
    bit     un_m [NI];
    rst_n = r; en = e; down = d; load = l;
    lm = 4'(tens); ll = 4'(units);
    for (int i = 0; i < NI; i++) begin
      bit ei, li;
      int lv;
      ei = (i == 3) ? (ov_m[0] | un_m[0]) : e;
      li = (i == 3) ? 1'b0 : l;
      ov_m[i] = ei && !d && !li && (mval[i] == maxv[i]);
      un_m[i] = ei &&  d && !li && (mval[i] == minv[i]);
      f.inst[i].msd = 4'(mval[i] / 10);
      f.inst[i].lsd = 4'(mval[i] % 10);
      f.inst[i].ov  = ov_m[i];
      f.inst[i].un  = un_m[i];
      f.inst[i].err = merr[i];
      if (!r) begin
        mval[i] = rstv[i];
        merr[i] = 1'b0;
      end else if (li) begin
        lv = tens * 10 + units;
        if (tens <= 9 && units <= 9 && lv >= minv[i] && lv <= maxv[i]) begin
          mval[i] = lv;
          merr[i] = 1'b0;
        end else begin
          merr[i] = 1'b1;
        end
      end else begin
        merr[i] = 1'b0;
        if (ei) begin
          if (d) mval[i] = (mval[i] == minv[i]) ? maxv[i] : mval[i] - 1;
          else   mval[i] = (mval[i] == maxv[i]) ? minv[i] : mval[i] + 1;
        end
      end
    end
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: every cycle presents a full observation frame.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      frame_t f;
      f = exp_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        obs_t a;
        a = '{msd: msd_w[i], lsd: lsd_w[i], ov: ov_w[i], un: un_w[i], err: err_w[i]};
        checks++;
        if (a !== f.inst[i]) begin
          failures++;
          $display("FAIL inst%0d cyc%0d got %h%h ov=%b un=%b err=%b required %h%h ov=%b un=%b err=%b",
                   i, cyc, a.msd, a.lsd, a.ov, a.un, a.err,
                   f.inst[i].msd, f.inst[i].lsd, f.inst[i].ov, f.inst[i].un, f.inst[i].err);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; down = 1'b0; load = 1'b0; lm = 4'd0; ll = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      mval[i] = rstv[i];
      merr[i] = 1'b0;
    end
    // Reset held with en high.
    cycle(0, 1, 0, 0, 0, 0);
    // Full hour of up-counting: chain goes 59:59 -> 00:00.
    for (int k = 0; k < 3600; k++) cycle(1, 1, 0, 0, 0, 0);
    // Down-count through wrap points.
    for (int k = 0; k < 30; k++) cycle(1, 1, 1, 0, 0, 0);
    // Directed loads: valid, out of range, non-BCD.
    cycle(1, 0, 0, 1, 1, 9);
    cycle(1, 0, 0, 1, 2, 4);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 10);
    cycle(1, 1, 0, 0, 0, 0);
    // Load beats en at the top of range.
    cycle(1, 0, 0, 1, 5, 9);
    cycle(1, 1, 0, 1, 0, 5);
    cycle(1, 1, 0, 1, 1, 2);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 1);
    cycle(1, 1, 1, 0, 0, 0);
    // Reset beats load.
    cycle(0, 1, 0, 1, 1, 1);
    // Hold at 37 (rejected on the hour counters).
    cycle(1, 0, 0, 1, 3, 7);
    for (int k = 0; k < 10; k++) cycle(1, 0, $urandom_range(0, 1), 0, 0, 0);
    // Randomised traffic.
    for (int k = 0; k < 2000; k++) begin
      bit r, e, d, l;
      int t, u;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      l = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 15);
        u = $urandom_range(0, 15);
      end else begin
        t = $urandom_range(0, 5);
        u = $urandom_range(0, 9);
      end
      cycle(r, e, d, l, t, u);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
